// File: rtl/ariane_clint_pkg.sv
// Shared register offsets, control register layout and tick-filter states for the CLINT timer.
package ariane_clint_pkg;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] MTIME_LO      = 16'hBFF8;
   localparam logic [15:0] MTIME_HI      = 16'hBFFC;
   localparam logic [15:0] CTRL_ADDR     = 16'hC000;

   typedef struct packed {
      logic [15:0] prescale;
      logic [13:0] rsvd;
      logic        src;
      logic        en;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{prescale: 16'h0000, rsvd: 14'h0000, src: 1'b0, en: 1'b1};

   typedef enum logic [1:0] {WAIT_HIGH, COUNT, TICK, WAIT_LOW} tick_state_e;

endpackage

// File: rtl/ariane_clint_tick_gen.sv
// Tick source: synchronised and debounced RTC edge filter or HCLK prescaler, gated by EN.
module ariane_clint_tick_gen
   import ariane_clint_pkg::*;
#(
   parameter int STABLE_CYCLES = 5
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        rtc_i,
   input  logic        en,
   input  logic        src,
   input  logic [15:0] prescale,
   input  logic        ctrl_wr,
   input  logic [15:0] wr_prescale,
   output logic        tick
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic          rtc_meta_q, rtc_s_q;
   tick_state_e   state_q;
   logic [CW-1:0] count_q;
   logic          rtc_tick_q;
   logic [15:0]   pre_cnt_q;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rtc_meta_q <= 1'b0;
         rtc_s_q    <= 1'b0;
         state_q    <= WAIT_HIGH;
         count_q    <= '0;
         rtc_tick_q <= 1'b0;
      end else begin
         rtc_meta_q <= rtc_i;
         rtc_s_q    <= rtc_meta_q;
         rtc_tick_q <= 1'b0;
         case (state_q)
            WAIT_HIGH: if (rtc_s_q) begin
               count_q <= CW'(1);
               state_q <= COUNT;
            end
            COUNT: begin
               if (!rtc_s_q) begin
                  count_q <= '0;
                  state_q <= WAIT_HIGH;
               end else if (count_q == CW'(STABLE_CYCLES)) begin
                  rtc_tick_q <= 1'b1;
                  state_q    <= TICK;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            TICK: begin
               count_q <= '0;
               state_q <= WAIT_LOW;
            end
            WAIT_LOW: if (!rtc_s_q) state_q <= WAIT_HIGH;
            default:  state_q <= WAIT_HIGH;
         endcase
      end
   end

   // A CTRL write restarts the period with the value being written.
   always_ff @(posedge HCLK) begin
      if (HRESET)                            pre_cnt_q <= '0;
      else if (ctrl_wr)                      pre_cnt_q <= wr_prescale;
      else if (!en || pre_cnt_q == 16'd0)    pre_cnt_q <= prescale;
      else                                   pre_cnt_q <= pre_cnt_q - 16'd1;
   end

   assign tick = en & (src ? (pre_cnt_q == 16'd0) : rtc_tick_q);

endmodule

// File: rtl/ariane_clint_timer.sv
// CLINT machine timer: APB register file for msip/mtimecmp/mtime/CTRL, coherent mtime reads, IRQ compare.
module ariane_clint_timer
   import ariane_clint_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 16,
   parameter int unsigned NR_CORES       = 4,
   parameter int unsigned STABLE_CYCLES  = 5
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic                      rtc_i,
   output logic [63:0]               time_o,
   output logic [NR_CORES-1:0]       timer_irq_o,
   output logic [NR_CORES-1:0]       soft_irq_o
);

   logic [15:0]         off;
   logic [9:0]          idx_msip, idx_cmp;
   logic                access, rd, wr;
   logic                msip_sel, cmp_sel, mtime_lo_sel, mtime_hi_sel, ctrl_sel, mapped;
   logic                tick;
   ctrl_t               ctrl_q;
   logic [63:0]         mtime_q;
   logic [63:0]         mtimecmp_q [NR_CORES];
   logic [NR_CORES-1:0] msip_q;
   logic [31:0]         hi_shadow_q;

   assign off      = PADDR[15:0];
   assign idx_msip = off[11:2];
   assign idx_cmp  = off[12:3];
   assign access   = PSEL & PENABLE & ~HRESET;
   assign rd       = access & ~PWRITE;
   assign wr       = access & PWRITE;

   assign msip_sel     = (off[15:12] == MSIP_BASE[15:12]) && (off[1:0] == 2'b00)
                         && (32'(idx_msip) < NR_CORES);
   assign cmp_sel      = (off[15:13] == MTIMECMP_BASE[15:13]) && (off[1:0] == 2'b00)
                         && (32'(idx_cmp) < NR_CORES);
   assign mtime_lo_sel = (off == MTIME_LO);
   assign mtime_hi_sel = (off == MTIME_HI);
   assign ctrl_sel     = (off == CTRL_ADDR);
   assign mapped       = msip_sel | cmp_sel | mtime_lo_sel | mtime_hi_sel | ctrl_sel;

   assign PREADY  = 1'b1;
   assign PSLVERR = access & ~mapped;

   ariane_clint_tick_gen #(.STABLE_CYCLES(int'(STABLE_CYCLES))) u_tick_gen (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .rtc_i       (rtc_i),
      .en          (ctrl_q.en),
      .src         (ctrl_q.src),
      .prescale    (ctrl_q.prescale),
      .ctrl_wr     (wr & ctrl_sel),
      .wr_prescale (PWDATA[31:16]),
      .tick        (tick)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ctrl_q      <= CTRL_RESET;
         mtime_q     <= '0;
         msip_q      <= '0;
         hi_shadow_q <= '0;
         for (int h = 0; h < int'(NR_CORES); h++) mtimecmp_q[h] <= '1;
      end else begin
         if (wr && ctrl_sel)
            ctrl_q <= '{prescale: PWDATA[31:16], rsvd: 14'h0000, src: PWDATA[1], en: PWDATA[0]};
         for (int h = 0; h < int'(NR_CORES); h++) begin
            if (wr && msip_sel && idx_msip == 10'(h)) msip_q[h] <= PWDATA[0];
            if (wr && cmp_sel && idx_cmp == 10'(h)) begin
               if (off[2]) mtimecmp_q[h][63:32] <= PWDATA;
               else        mtimecmp_q[h][31:0]  <= PWDATA;
            end
         end
         // Software writes own mtime for the cycle; a coincident tick is lost.
         if (wr && mtime_lo_sel)      mtime_q[31:0]  <= PWDATA;
         else if (wr && mtime_hi_sel) mtime_q[63:32] <= PWDATA;
         else if (tick)               mtime_q        <= mtime_q + 64'd1;
         if (rd && mtime_lo_sel) hi_shadow_q <= mtime_q[63:32];
      end
   end

   always_comb begin
      PRDATA = '0;
      if (rd) begin
         if (msip_sel || cmp_sel) begin
            for (int h = 0; h < int'(NR_CORES); h++) begin
               if (msip_sel && idx_msip == 10'(h)) PRDATA = {31'b0, msip_q[h]};
               if (cmp_sel && idx_cmp == 10'(h))
                  PRDATA = off[2] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
            end
         end else if (mtime_lo_sel) begin
            PRDATA = mtime_q[31:0];
         end else if (mtime_hi_sel) begin
            PRDATA = hi_shadow_q;
         end else if (ctrl_sel) begin
            PRDATA = ctrl_q;
         end
      end
   end

   always_comb begin
      for (int h = 0; h < int'(NR_CORES); h++) timer_irq_o[h] = (mtime_q >= mtimecmp_q[h]);
   end

   assign soft_irq_o = msip_q;
   assign time_o     = mtime_q;

endmodule

// File: tb/tb_ariane_clint_timer.sv
// Bench for ariane_clint_timer: directed scenarios plus randomized register/RTC traffic vs a reference model.
module tb_ariane_clint_timer;

   localparam int NR = 4;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [15:0]   PADDR;
   logic [31:0]   PWDATA, PRDATA;
   logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR, rtc_i;
   logic [63:0]   time_o;
   logic [NR-1:0] timer_irq_o, soft_irq_o;

   ariane_clint_timer #(.APB_ADDR_WIDTH(16), .NR_CORES(NR), .STABLE_CYCLES(5)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .rtc_i(rtc_i), .time_o(time_o), .timer_irq_o(timer_irq_o), .soft_irq_o(soft_irq_o)
   );

   // clock / reset
   always #5 HCLK = ~HCLK;

   // reference model and scoreboard
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [63:0]   exp_q[$];
   logic [63:0]   m_mtime;
   logic [63:0]   m_cmp [NR];
   logic [NR-1:0] m_msip;
   logic [31:0]   rdata;
   logic          rerr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [NR-1:0] model_irq();
      logic [NR-1:0] v;
      for (int h = 0; h < NR; h++) v[h] = (m_mtime >= m_cmp[h]);
      return v;
   endfunction

   task automatic model_reset();
      m_mtime = '0;
      m_msip  = '0;
      for (int h = 0; h < NR; h++) m_cmp[h] = '1;
   endtask

   // driver tasks (inputs change on negedge, outputs sampled on negedge)
   task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge HCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
      @(negedge HCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      d = PRDATA; err = PSLVERR;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic write_mtime(input logic [63:0] v);
      apb_write(16'hBFF8, v[31:0]);
      apb_write(16'hBFFC, v[63:32]);
      m_mtime = v;
   endtask

   task automatic write_cmp(input int h, input logic [63:0] v);
      apb_write(16'(16'h4000 + 8 * h), v[31:0]);
      apb_write(16'(16'h4004 + 8 * h), v[63:32]);
      m_cmp[h] = v;
   endtask

   task automatic rtc_pulse(input int high, input int low);
      @(negedge HCLK);
      rtc_i = 1'b1;
      repeat (high) @(negedge HCLK);
      rtc_i = 1'b0;
      repeat (low) @(negedge HCLK);
   endtask

   task automatic reset_checks(input string pfx);
      check({pfx, "_time"}, time_o, 64'h0);
      check({pfx, "_timer_irq"}, 64'(timer_irq_o), 64'h0);
      check({pfx, "_soft_irq"}, 64'(soft_irq_o), 64'h0);
      check({pfx, "_pready"}, 64'(PREADY), 64'h1);
      apb_read(16'hC000, rdata, rerr);
      check({pfx, "_ctrl"}, 64'(rdata), 64'h1);
      apb_read(16'h4000, rdata, rerr);
      check({pfx, "_cmp0_lo"}, 64'(rdata), 64'hFFFF_FFFF);
      apb_read(16'h4004, rdata, rerr);
      check({pfx, "_cmp0_hi"}, 64'(rdata), 64'hFFFF_FFFF);
   endtask

   initial begin
      logic [63:0] t0, v;
      int          idx, nticks, hi_len;
      logic        seen, long_p;

      HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; rtc_i = 1'b0;
      model_reset();
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;

      // 1. reset state and unmapped access
      reset_checks("rst");
      apb_read(16'hD000, rdata, rerr);
      check("unmapped_slverr", 64'(rerr), 64'h1);
      check("unmapped_prdata", 64'(rdata), 64'h0);

      // 2. RTC filter: short glitch ignored, long high gives exactly one tick
      rtc_pulse(4, 12);
      check("rtc_glitch", time_o, m_mtime);
      rtc_pulse(200, 12);
      m_mtime += 1;
      check("rtc_long", time_o, m_mtime);

      // 3. prescaler period and EN freeze
      apb_write(16'hC000, 32'h0003_0003);
      t0 = time_o;
      repeat (40) @(negedge HCLK);
      check("presc_rate", time_o - t0, 64'd10);
      apb_write(16'hC000, 32'h0003_0002);
      t0 = time_o;
      repeat (50) @(negedge HCLK);
      check("en_freeze", time_o - t0, 64'd0);
      apb_write(16'hC000, 32'h0000_0001);

      // 5. compare on hart 2
      write_mtime(64'hF);
      write_cmp(2, 64'h10);
      check("cmp_before", 64'(timer_irq_o), 64'(model_irq()));
      @(negedge HCLK);
      rtc_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge HCLK);
         if (time_o != m_mtime) begin
            seen = 1'b1;
            check("cmp_tick_time", time_o, 64'h10);
            check("cmp_tick_irq", 64'(timer_irq_o), 64'h4);
         end
      end
      if (!seen) check("cmp_tick_timeout", 64'(seen), 64'h1);
      rtc_i = 1'b0;
      repeat (12) @(negedge HCLK);
      m_mtime += 1;
      apb_write(16'h4014, 32'h1);
      m_cmp[2] = 64'h1_0000_0010;
      check("cmp_clear", 64'(timer_irq_o), 64'(model_irq()));

      // 4. coherent split read across a carry
      write_mtime(64'h0000_0000_FFFF_FFFF);
      apb_read(16'hBFF8, rdata, rerr);
      check("coh_lo", 64'(rdata), 64'hFFFF_FFFF);
      rtc_pulse(30, 12);
      m_mtime += 1;
      apb_read(16'hBFFC, rdata, rerr);
      check("coh_hi_shadow", 64'(rdata), 64'h0);
      check("coh_live", time_o, m_mtime);

      // wrap 2^64-1 -> 0
      write_mtime('1);
      rtc_pulse(30, 12);
      m_mtime += 1;
      check("wrap", time_o, m_mtime);

      // 6. msip and write/tick collision
      apb_write(16'h000C, 32'h1);
      m_msip[3] = 1'b1;
      check("msip3", 64'(soft_irq_o), 64'(m_msip));
      apb_write(16'hC000, 32'h0000_0003);
      apb_write(16'hBFF8, 32'h5);
      check("tick_vs_write", 64'(time_o[31:0]), 64'h5);
      apb_write(16'hC000, 32'h0000_0000);

      // randomized register traffic with mtime frozen
      for (int it = 0; it < 8; it++) begin
         write_mtime({$urandom(), $urandom()});
         for (int h = 0; h < NR; h++) begin
            if ($urandom_range(0, 1) == 1) v = m_mtime + 64'(signed'($urandom_range(0, 4)) - 2);
            else v = {$urandom(), $urandom()};
            write_cmp(h, v);
            m_msip[h] = 1'($urandom_range(0, 1));
            apb_write(16'(4 * h), {$urandom_range(0, 32'h7FFF) << 1, m_msip[h]});
         end
         check("rnd_timer_irq", 64'(timer_irq_o), 64'(model_irq()));
         check("rnd_soft_irq", 64'(soft_irq_o), 64'(m_msip));
         for (int h = 0; h < NR; h++) begin
            exp_q.push_back(m_cmp[h][31:0]);
            exp_q.push_back(m_cmp[h][63:32]);
            exp_q.push_back(64'(m_msip[h]));
         end
         for (int h = 0; h < NR; h++) begin
            apb_read(16'(16'h4000 + 8 * h), rdata, rerr);
            check("rnd_cmp_lo", 64'(rdata), exp_q.pop_front());
            apb_read(16'(16'h4004 + 8 * h), rdata, rerr);
            check("rnd_cmp_hi", 64'(rdata), exp_q.pop_front());
            apb_read(16'(4 * h), rdata, rerr);
            check("rnd_msip", 64'(rdata), exp_q.pop_front());
         end
         idx = $urandom_range(NR, 1023);
         apb_read(($urandom_range(0, 1) == 1) ? 16'(4 * idx) : 16'(16'h4000 + 8 * idx), rdata, rerr);
         check("rnd_oob_err", 64'(rerr), 64'h1);
         check("rnd_oob_data", 64'(rdata), 64'h0);
      end

      // randomized RTC pulses against tick count
      apb_write(16'hC000, 32'h0000_0001);
      write_mtime({$urandom(), $urandom()});
      nticks = 0;
      for (int p = 0; p < 6; p++) begin
         long_p = 1'($urandom_range(0, 1));
         hi_len = long_p ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 4));
         rtc_pulse(hi_len, 12);
         if (long_p) nticks++;
      end
      m_mtime += 64'(nticks);
      check("rnd_rtc_ticks", time_o, m_mtime);
      check("rnd_rtc_irq", 64'(timer_irq_o), 64'(model_irq()));

      // write colliding with reset is dropped
      @(negedge HCLK);
      HRESET = 1'b1;
      apb_write(16'h000C, 32'h1);
      HRESET = 1'b0;
      model_reset();
      check("rst_write_msip", 64'(soft_irq_o), 64'(m_msip));
      reset_checks("rst2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
